// File: rtl/alu_decode_md_pkg.sv
// Shared encodings for the ALU decoder and its multiply/divide sequencer.
package alu_pkg;

    // Main-decoder ALU op classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // Extended ALU control words
    localparam logic [4:0] ALUCTRL_ADD = 5'b00000;
    localparam logic [4:0] ALUCTRL_SUB = 5'b00001;
    localparam logic [4:0] ALUCTRL_MD  = 5'b10000;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

    // M-extension funct3 codes
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

endpackage

// File: rtl/alu_decode_md_md_iter_core.sv
// Iterative unsigned engine: shift-add multiplier or restoring divider,
// one step per clock, WIDTH steps per operation. Works on magnitudes only.
module md_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op,       // 1 = divide, 0 = multiply
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic               busy,     // high while steps remain after this cycle
    output logic [2*WIDTH-1:0] result    // mul: {hi,lo} product; div: {rem,quot}
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] hi, lo, divisor;
    logic             div_mode;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   mul_sum, shifted, diff;

    // One combinational step of either algorithm on the shared {hi,lo} pair
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, divisor} : '0);
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
    end

    // Load on start, then step once per cycle until the counter drains
    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            divisor  <= '0;
            div_mode <= 1'b0;
            count    <= '0;
        end else if (start) begin
            hi       <= '0;
            lo       <= a_mag;
            divisor  <= b_mag;
            div_mode <= op;
            count    <= CW'(WIDTH);
        end else if (count != '0) begin
            count <= count - 1'b1;
            if (div_mode) begin
                hi <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
                hi <= mul_sum[WIDTH:1];
                lo <= {mul_sum[0], lo[WIDTH-1:1]};
            end
        end
    end

    assign busy   = (count > CW'(1));
    assign result = {hi, lo};

endmodule

// File: rtl/alu_decode_md.sv
// ALU control decoder with an RV32M multiply/divide sequencer that stalls
// the pipeline while the iterative engine runs.
module alu_decode_md
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FAST_MUL = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic [4:0]       ALUctrl_o,
    output logic [WIDTH-1:0] md_result_o,
    output logic             md_done_o,
    output logic             stall_o
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_t state, state_next;

    logic               m_op, start, core_busy;
    logic               a_signed, b_signed, a_neg, b_neg, is_div;
    logic               div_zero, ovf, fast;
    logic [WIDTH-1:0]   a_mag, b_mag, fast_value, fixed_value, done_value;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod_full, core_res, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    logic [2:0]         op_q;
    logic               quot_neg_q, rem_neg_q, fast_q;
    logic [WIDTH-1:0]   fast_val_q, result_q;

    assign m_op = valid_i && (ALUOp_i == ALUOP_RTYPE) && (funct7_i == FUNCT7_MULDIV);

    // ALU control decode
    always_comb begin
        ALUctrl_o = ALUCTRL_ADD;
        case (ALUOp_i)
            ALUOP_ADD: ALUctrl_o = ALUCTRL_ADD;
            ALUOP_SUB: ALUctrl_o = ALUCTRL_SUB;
            ALUOP_RTYPE:
                if (funct7_i == FUNCT7_MULDIV) ALUctrl_o = ALUCTRL_MD | {1'b0, funct3_i, 1'b0};
                else                           ALUctrl_o = {1'b0, funct3_i, funct7_i[5]};
            default:
                if (funct3_i == FUNCT3_SRL_SRA) ALUctrl_o = {1'b0, funct3_i, funct7_i[5]};
                else                            ALUctrl_o = {1'b0, funct3_i, 1'b0};
        endcase
    end

    // Operand signs, magnitudes and the single-cycle special cases
    always_comb begin
        a_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                   (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
        b_signed = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
        a_neg    = a_signed & src_a_i[WIDTH-1];
        b_neg    = b_signed & src_b_i[WIDTH-1];
        a_mag    = a_neg ? -src_a_i : src_a_i;
        b_mag    = b_neg ? -src_b_i : src_b_i;
        is_div   = funct3_i[2];
        div_zero = is_div && (src_b_i == '0);
        ovf      = is_div && !funct3_i[0] && (src_a_i == MIN_NEG) && (src_b_i == '1);
        a_ext    = a_signed ? {{WIDTH{src_a_i[WIDTH-1]}}, src_a_i} : {{WIDTH{1'b0}}, src_a_i};
        b_ext    = b_signed ? {{WIDTH{src_b_i[WIDTH-1]}}, src_b_i} : {{WIDTH{1'b0}}, src_b_i};
        prod_full = a_ext * b_ext;
        fast     = div_zero || ovf || ((FAST_MUL != 0) && !is_div);
        if (div_zero)  fast_value = funct3_i[1] ? src_a_i : '1;
        else if (ovf)  fast_value = funct3_i[1] ? '0 : src_a_i;
        else           fast_value = (funct3_i == F3_MUL) ? prod_full[WIDTH-1:0]
                                                         : prod_full[2*WIDTH-1:WIDTH];
    end

    assign start = (state == MD_IDLE) && m_op && !flush_i;

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk_i),
        .rst    (rst_i),
        .start  (start && !fast),
        .op     (is_div),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .busy   (core_busy),
        .result (core_res)
    );

    // Sign correction of the engine output for the latched operation
    always_comb begin
        prod_fix = quot_neg_q ? -core_res : core_res;
        quot_fix = quot_neg_q ? -core_res[WIDTH-1:0] : core_res[WIDTH-1:0];
        rem_fix  = rem_neg_q ? -core_res[2*WIDTH-1:WIDTH] : core_res[2*WIDTH-1:WIDTH];
        if (op_q[2])              fixed_value = op_q[1] ? rem_fix : quot_fix;
        else if (op_q == F3_MUL)  fixed_value = prod_fix[WIDTH-1:0];
        else                      fixed_value = prod_fix[2*WIDTH-1:WIDTH];
        done_value = fast_q ? fast_val_q : fixed_value;
    end

    // Sequencer next state
    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (start) state_next = fast ? MD_DONE : MD_BUSY;
            MD_BUSY: begin
                if (flush_i)         state_next = MD_IDLE;
                else if (!core_busy) state_next = MD_DONE;
            end
            default: state_next = MD_IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= MD_IDLE;
        else       state <= state_next;
    end

    // Per-operation context captured at start, and the held result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q       <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            fast_q     <= 1'b0;
            fast_val_q <= '0;
            result_q   <= '0;
        end else begin
            if (start) begin
                op_q       <= funct3_i;
                quot_neg_q <= a_neg ^ b_neg;
                rem_neg_q  <= a_neg;
                fast_q     <= fast;
                fast_val_q <= fast_value;
            end
            if (state == MD_DONE) result_q <= done_value;
        end
    end

    // The done cycle exposes the fresh value directly; afterwards it is held
    assign md_done_o   = (state == MD_DONE) && !rst_i;
    assign md_result_o = md_done_o ? done_value : result_q;
    assign stall_o     = !rst_i && (((state == MD_IDLE) && start) ||
                                    ((state == MD_BUSY) && !flush_i));

endmodule

// File: tb/tb_alu_decode_md.sv
// Randomized self-checking bench for alu_decode_md, one iterative and one
// fast-multiply instance, against an arithmetic reference model.
module tb_alu_decode_md;

    logic        clk = 1'b0;
    logic        rst, valid_s, valid_f, flush;
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b;
    logic [4:0]  ctrl_s, ctrl_f;
    logic [31:0] res_s, res_f;
    logic        done_s, done_f, stall_s, stall_f;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_s = '0;
    logic [31:0] last_f = '0;

    always #5 clk = ~clk;

    alu_decode_md #(.WIDTH(32), .FAST_MUL(0)) dut_s (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_s), .flush_i(flush),
        .ALUOp_i(aluop), .funct3_i(f3), .funct7_i(f7), .src_a_i(a), .src_b_i(b),
        .ALUctrl_o(ctrl_s), .md_result_o(res_s), .md_done_o(done_s), .stall_o(stall_s)
    );

    alu_decode_md #(.WIDTH(32), .FAST_MUL(1)) dut_f (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_f), .flush_i(flush),
        .ALUOp_i(aluop), .funct3_i(f3), .funct7_i(f7), .src_a_i(a), .src_b_i(b),
        .ALUctrl_o(ctrl_f), .md_result_o(res_f), .md_done_o(done_f), .stall_o(stall_f)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [2:0] fn3,
                                           input logic [6:0] fn7);
        case (op)
            2'b00: return 5'b00000;
            2'b01: return 5'b00001;
            2'b10: return (fn7 == 7'b0000001) ? {1'b1, fn3, 1'b0} : {1'b0, fn3, fn7[5]};
            default: return (fn3 == 3'b101) ? {1'b0, fn3, fn7[5]} : {1'b0, fn3, 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
        longint sx, sy, p;
        longint unsigned up;
        logic [63:0] bits;
        sx = $signed(x);
        sy = $signed(y);
        case (op)
            3'd0: begin up = longint'(x) * longint'(y); bits = up; return bits[31:0]; end
            3'd1: begin p = sx * sy; bits = p; return bits[63:32]; end
            3'd2: begin p = sx * longint'({32'h0, y}); bits = p; return bits[63:32]; end
            3'd3: begin up = {32'h0, x} * {32'h0, y}; bits = up; return bits[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
                p = sx / sy; bits = p; return bits[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                p = sx % sy; bits = p; return bits[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit ref_fast(input bit fast_dut, input logic [2:0] op,
                                    input logic [31:0] x, input logic [31:0] y);
        if (op[2] && y == 0) return 1'b1;
        if ((op == 3'd4 || op == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1'b1;
        return fast_dut && !op[2];
    endfunction

    // Issue one M op to the chosen instance and follow it to its done pulse
    task automatic run_op(input bit fd, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input string tag);
        logic [31:0] exp_r;
        int lat, k, stall_err;
        bit seen;
        exp_r = ref_md(op, x, y);
        lat   = ref_fast(fd, op, x, y) ? 1 : 33;
        @(negedge clk);
        aluop = 2'b10; f7 = 7'b0000001; f3 = op; a = x; b = y;
        valid_s = !fd; valid_f = fd;
        #1;
        chk({tag, "/stall_c0"}, fd ? stall_f : stall_s, 1);
        chk({tag, "/ctrl"}, fd ? ctrl_f : ctrl_s, {1'b1, op, 1'b0});
        k = 0; seen = 0; stall_err = 0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (fd ? done_f : done_s) seen = 1;
            else if ((fd ? stall_f : stall_s) !== 1'b1) stall_err++;
        end
        chk({tag, "/latency"}, k, lat);
        chk({tag, "/result"}, fd ? res_f : res_s, exp_r);
        chk({tag, "/stall_done"}, fd ? stall_f : stall_s, 0);
        chk({tag, "/stall_busy"}, stall_err, 0);
        if (fd) last_f = exp_r; else last_s = exp_r;
        valid_s = 0; valid_f = 0;
        @(negedge clk);
        chk({tag, "/pulse"}, fd ? done_f : done_s, 0);
        chk({tag, "/held"}, fd ? res_f : res_s, exp_r);
    endtask

    task automatic decode_case(input logic [1:0] op, input logic [2:0] fn3,
                               input logic [6:0] fn7, input string tag);
        @(negedge clk);
        aluop = op; f3 = fn3; f7 = fn7; valid_s = 1; valid_f = 0;
        a = $urandom; b = $urandom;
        #1;
        chk({tag, "/ctrl"}, ctrl_s, ref_dec(op, fn3, fn7));
        chk({tag, "/stall"}, stall_s, 0);
        @(negedge clk);
        chk({tag, "/nodone"}, done_s, 0);
        chk({tag, "/res_held"}, res_s, last_s);
        valid_s = 0;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [6:0]  rf7;
        int nd;

        rst = 1; flush = 0; valid_f = 0;
        aluop = 2'b10; f7 = 7'b0000001; f3 = 3'd4; a = 32'd100; b = 32'd7; valid_s = 1;
        #1;
        chk("reset/stall", stall_s, 0);
        repeat (3) @(negedge clk);
        valid_s = 0;
        rst = 0;
        @(negedge clk);
        chk("reset/result", res_s, 0);
        chk("reset/done", done_s, 0);
        chk("reset/stall_after", stall_s, 0);

        decode_case(2'b10, 3'b000, 7'b0100000, "dec_sub");
        decode_case(2'b11, 3'b101, 7'b0100000, "dec_srai");
        decode_case(2'b00, 3'b111, 7'b0100000, "dec_add");
        decode_case(2'b01, 3'b010, 7'b0000000, "dec_sub_class");
        decode_case(2'b11, 3'b001, 7'b0100000, "dec_itype");
        for (int i = 0; i < 20; i++) begin
            rf7 = 7'($urandom);
            if (rf7 == 7'b0000001) rf7 = 7'b0100000;
            decode_case(2'($urandom), 3'($urandom), rf7, "dec_rand");
        end

        run_op(0, 3'd0, 32'd7, 32'hFFFFFFFD, "mul");
        run_op(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu");
        run_op(0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulh");
        run_op(0, 3'd2, 32'hFFFFFFFF, 32'd2, "mulhsu");
        run_op(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        run_op(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");
        run_op(0, 3'd5, 32'd100, 32'd0, "divu_zero");
        run_op(0, 3'd7, 32'd100, 32'd0, "remu_zero");

        // Flush part-way through a divide
        @(negedge clk);
        aluop = 2'b10; f7 = 7'b0000001; f3 = 3'd4; a = -32'sd20; b = 32'd3; valid_s = 1;
        repeat (10) @(negedge clk);
        flush = 1; valid_s = 0;
        #1;
        chk("flush/stall_now", stall_s, 0);
        @(negedge clk);
        flush = 0;
        chk("flush/stall_next", stall_s, 0);
        chk("flush/result", res_s, last_s);
        nd = 0;
        repeat (40) begin @(negedge clk); if (done_s) nd++; end
        chk("flush/no_done", nd, 0);
        run_op(0, 3'd4, -32'sd20, 32'd3, "div_reissue");
        run_op(0, 3'd6, -32'sd20, 32'd3, "rem_neg");

        // Flush while idle must block the start
        @(negedge clk);
        aluop = 2'b10; f7 = 7'b0000001; f3 = 3'd5; a = 32'd9; b = 32'd2; valid_s = 1; flush = 1;
        #1;
        chk("flush_idle/stall", stall_s, 0);
        @(negedge clk);
        valid_s = 0; flush = 0;
        chk("flush_idle/stall_next", stall_s, 0);
        nd = 0;
        repeat (40) begin @(negedge clk); if (done_s) nd++; end
        chk("flush_idle/no_done", nd, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom);
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: begin ra = $urandom_range(0, 300); rb = $urandom_range(0, 20); end
                3: rb = -32'($urandom_range(1, 50));
                default: ;
            endcase
            run_op(0, rop, ra, rb, "rand");
        end

        run_op(1, 3'd0, 32'h00010000, 32'h00010000, "fast_mul");
        run_op(1, 3'd1, 32'h80000000, 32'h80000000, "fast_mulh");
        for (int i = 0; i < 6; i++)
            run_op(1, 3'($urandom), $urandom, $urandom, "fast_rand");

        // Reset in the middle of an iterative divide
        @(negedge clk);
        aluop = 2'b10; f7 = 7'b0000001; f3 = 3'd4; a = 32'd1000; b = 32'd7; valid_s = 1;
        repeat (5) @(negedge clk);
        rst = 1; valid_s = 0;
        #1;
        chk("rst_mid/stall", stall_s, 0);
        @(negedge clk);
        rst = 0;
        last_s = '0;
        chk("rst_mid/result", res_s, 0);
        nd = 0;
        repeat (40) begin @(negedge clk); if (done_s) nd++; end
        chk("rst_mid/no_done", nd, 0);
        chk("rst_mid/result_late", res_s, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
